// File: rtl/scaler_mc_pkg.sv
// Shared defaults and channel-index width derivation for the multi-channel gain scaler.
package scaler_mc_pkg;

   localparam int          WIDTH_DEF    = 16;
   localparam int          CHANNELS_DEF = 4;
   localparam int unsigned STEP_DEF     = 256;

   function automatic int chan_width(input int channels);
      int w;
      w = $clog2(channels);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/scaler_mul.sv
// Two-stage signed-sample by unsigned-gain multiply, keeping bits [2W-1:W] of the product.
module scaler_mul
   import scaler_mc_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk48m,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] sample,
   input  logic [WIDTH-1:0] gain,
   output logic [WIDTH-1:0] result
);

   logic signed [2*WIDTH:0] sample_ext_s;
   logic signed [2*WIDTH:0] gain_ext_s;
   logic signed [2*WIDTH:0] product_r;
   logic        [WIDTH-1:0] result_r;
   logic                    unused_bits_s;

   assign sample_ext_s = (2*WIDTH+1)'($signed(sample));
   assign gain_ext_s   = (2*WIDTH+1)'($signed({1'b0, gain}));

   // Stage 1 holds the full product; stage 2 keeps the floor-shifted slice (no saturation).
   always_ff @(posedge clk48m or posedge rst) begin
      if (rst) begin
         product_r <= '0;
         result_r  <= '0;
      end else if (en) begin
         product_r <= sample_ext_s * gain_ext_s;
         result_r  <= product_r[2*WIDTH-1:WIDTH];
      end
   end

   assign result        = result_r;
   assign unused_bits_s = ^{product_r[2*WIDTH], product_r[WIDTH-1:0]};

endmodule

// File: rtl/scaler_mc.sv
// Multi-channel sample scaler: per-channel target/current gain with ramping, two-stage pipeline.
module scaler_mc
   import scaler_mc_pkg::*;
#(
   parameter  int          WIDTH    = WIDTH_DEF,
   parameter  int          CHANNELS = CHANNELS_DEF,
   parameter  int unsigned STEP     = STEP_DEF,
   localparam int          CW       = chan_width(CHANNELS)
) (
   input  logic             clk48m,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CW-1:0]    in_chan,
   input  logic [WIDTH-1:0] in_sample,
   input  logic             gain_we,
   input  logic             gain_jump,
   input  logic [CW-1:0]    gain_chan,
   input  logic [WIDTH-1:0] gain_value,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    out_chan,
   output logic [WIDTH-1:0] out_sample
);

   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   logic [WIDTH-1:0] target_r  [CHANNELS];
   logic [WIDTH-1:0] current_r [CHANNELS];
   logic             en_s;
   logic             accept_s;
   logic             chan_ok_s;
   logic [WIDTH-1:0] gain_sel_s;
   logic             s1_valid_r;
   logic [CW-1:0]    s1_chan_r;
   logic             out_valid_r;
   logic [CW-1:0]    out_chan_r;

   function automatic logic [WIDTH-1:0] ramp_next(input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] tgt);
      logic [WIDTH-1:0] nxt;
      if (tgt >= cur) begin
         nxt = ((tgt - cur) <= STEP_W) ? tgt : cur + STEP_W;
      end else begin
         nxt = ((cur - tgt) <= STEP_W) ? tgt : cur - STEP_W;
      end
      return nxt;
   endfunction

   assign en_s      = !out_valid_r || out_ready;
   assign in_ready  = en_s;
   assign accept_s  = in_valid && en_s;
   assign chan_ok_s = int'(in_chan) < CHANNELS;

   // Gain used by the multiplier: out-of-range channels multiply by zero.
   always_comb begin
      gain_sel_s = '0;
      if (chan_ok_s) begin
         gain_sel_s = current_r[in_chan];
      end else begin
         gain_sel_s = '0;
      end
   end

   // Per-channel gain state: a gain write wins over the ramp step of a same-cycle sample.
   always_ff @(posedge clk48m or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            target_r[c]  <= '0;
            current_r[c] <= '0;
         end
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (gain_we && (int'(gain_chan) == c)) begin
               target_r[c] <= gain_value;
               if (gain_jump) begin
                  current_r[c] <= gain_value;
               end
            end else if (accept_s && (int'(in_chan) == c)) begin
               current_r[c] <= ramp_next(current_r[c], target_r[c]);
            end
         end
      end
   end

   // Valid/channel tags travel alongside the multiplier stages and stall together.
   always_ff @(posedge clk48m or posedge rst) begin
      if (rst) begin
         s1_valid_r  <= 1'b0;
         s1_chan_r   <= '0;
         out_valid_r <= 1'b0;
         out_chan_r  <= '0;
      end else if (en_s) begin
         s1_valid_r  <= in_valid;
         s1_chan_r   <= in_chan;
         out_valid_r <= s1_valid_r;
         out_chan_r  <= s1_chan_r;
      end
   end

   scaler_mul #(.WIDTH(WIDTH)) u_mul (
      .clk48m (clk48m),
      .rst    (rst),
      .en     (en_s),
      .sample (in_sample),
      .gain   (gain_sel_s),
      .result (out_sample)
   );

   assign out_valid = out_valid_r;
   assign out_chan  = out_chan_r;

endmodule

// File: tb/tb_scaler_mc.sv
// Directed bench for scaler_mc: expected results queued on accept, checked on output handshake.
module tb_scaler_mc;

   logic        clk48m = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_chan;
   logic [15:0] in_sample;
   logic        gain_we;
   logic        gain_jump;
   logic [1:0]  gain_chan;
   logic [15:0] gain_value;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_chan;
   logic [15:0] out_sample;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [17:0] exp_q [$];

   scaler_mc dut (
      .clk48m     (clk48m),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_chan    (in_chan),
      .in_sample  (in_sample),
      .gain_we    (gain_we),
      .gain_jump  (gain_jump),
      .gain_chan  (gain_chan),
      .gain_value (gain_value),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_chan   (out_chan),
      .out_sample (out_sample)
   );

   always #5 clk48m = ~clk48m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic gain(input logic [1:0] c, input logic [15:0] v, input logic j);
      gain_we = 1'b1; gain_chan = c; gain_value = v; gain_jump = j;
      @(posedge clk48m); #1;
      gain_we = 1'b0; gain_jump = 1'b0;
   endtask

   task automatic send(input logic [1:0] c, input logic [15:0] s, input logic [15:0] e);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1; in_chan = c; in_sample = s;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk48m);
         if (in_ready) ok = 1'b1;
      end
      @(posedge clk48m);
      if (ok) exp_q.push_back({c, e});
      #1;
      in_valid = 1'b0;
      chk("accept_timeout", {31'd0, ok}, 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk48m);
      #1;
      chk("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard: pop one expected result per output handshake.
   always @(negedge clk48m) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_output", 32'(exp_q.size()), 32'd1);
         end else begin
            logic [17:0] e;
            e = exp_q.pop_front();
            chk("out_chan", {30'd0, out_chan}, {30'd0, e[17:16]});
            chk("out_sample", {16'd0, out_sample}, {16'd0, e[15:0]});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_chan = 2'd0; in_sample = 16'd0;
      gain_we = 1'b0; gain_jump = 1'b0; gain_chan = 2'd0; gain_value = 16'd0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk48m);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_sample", {16'd0, out_sample}, 32'd0);
      chk("rst_out_chan", {30'd0, out_chan}, 32'd0);
      @(negedge clk48m); rst = 1'b0;
      @(posedge clk48m); #1;
      chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

      // Basic gain and 2-cycle latency
      gain(2'd0, 16'h8000, 1'b1);
      send(2'd0, 16'h4000, 16'h2000);
      chk("lat_stage1", {31'd0, out_valid}, 32'd0);
      @(posedge clk48m); #1;
      chk("lat_valid", {31'd0, out_valid}, 32'd1);
      chk("lat_sample", {16'd0, out_sample}, 32'h2000);
      chk("lat_chan", {30'd0, out_chan}, 32'd0);
      drain();

      // Floor rounding
      gain(2'd3, 16'h0001, 1'b1);
      send(2'd3, 16'hFFFF, 16'hFFFF);
      gain(2'd3, 16'hFFFF, 1'b1);
      send(2'd3, 16'h8000, 16'h8000);
      drain();

      // Ramp on ch1, ch2 untouched
      gain(2'd1, 16'h0300, 1'b0);
      send(2'd1, 16'h7FFF, 16'h0000);
      send(2'd1, 16'h7FFF, 16'h007F);
      send(2'd1, 16'h7FFF, 16'h00FF);
      send(2'd1, 16'h7FFF, 16'h017F);
      send(2'd1, 16'h7FFF, 16'h017F);
      send(2'd2, 16'h7FFF, 16'h0000);
      drain();

      // Backpressure: ch0 gain 0x8000
      out_ready = 1'b0;
      send(2'd0, 16'h0100, 16'h0080);
      send(2'd0, 16'h0200, 16'h0100);
      in_valid = 1'b1; in_chan = 2'd0; in_sample = 16'h0300;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk48m);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_hold_sample", {16'd0, out_sample}, 32'h0080);
         chk("bp_hold_chan", {30'd0, out_chan}, 32'd0);
      end
      @(posedge clk48m); #1;
      out_ready = 1'b1;
      send(2'd0, 16'h0300, 16'h0180);
      drain();

      // Reset mid-ramp on ch1
      gain(2'd1, 16'h0000, 1'b1);
      gain(2'd1, 16'h0300, 1'b0);
      send(2'd1, 16'h7FFF, 16'h0000);
      send(2'd1, 16'h7FFF, 16'h007F);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      exp_q.delete();
      @(negedge clk48m); rst = 1'b0;
      @(posedge clk48m); #1;
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      send(2'd1, 16'h7FFF, 16'h0000);
      drain();

      // Same-cycle jump write and sample on ch0: old gain (0) used, new gain applies next
      gain_we = 1'b1; gain_jump = 1'b1; gain_chan = 2'd0; gain_value = 16'h4000;
      send(2'd0, 16'h4000, 16'h0000);
      gain_we = 1'b0; gain_jump = 1'b0;
      send(2'd0, 16'h4000, 16'h1000);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
